// File: rtl/centisec_stopwatch.sv
// ============================================================================
// Module   : centisec_stopwatch
// Purpose  : Centisecond stopwatch. Accumulates ticks from the clock
//            modulator as a BCD MM:SS.cc count, runs a start/stop/clear/lap
//            control FSM and presents six registered BCD digits plus status
//            flags to the seven-segment display mux.
// Ports    : clk            - system clock
//            rst_n          - asynchronous active-low reset
//            tick_i         - centisecond tick
//            start_stop_i   - one-cycle pulse, toggles run/pause
//            clear_i        - one-cycle pulse, zero count/display/overflow
//            lap_i          - one-cycle pulse, freeze/unfreeze display
//            preset_load_i  - (countdown build) load preset while IDLE
//            preset_bcd_i   - (countdown build) {mm,ss,cc} BCD preset
//            *_ones_o/*_tens_o - displayed BCD digits
//            running_o      - high in RUN or LAP_RUN
//            lap_active_o   - high while the display is frozen
//            overflow_o     - sticky 59:59.99 boundary flag (done flag in
//                             countdown build)
// Options  : STOPWATCH_COUNTDOWN_EN - define to build the countdown variant
//            with preset inputs; undefined gives count-up only.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module centisec_stopwatch #(
  parameter int unsigned SATURATE    = 0,  // 1: hold at 59:59.99, 0: wrap
  parameter int unsigned EDGE_DETECT = 1   // 1: count tick rising edges
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_i,
  input  logic        start_stop_i,
  input  logic        clear_i,
  input  logic        lap_i,
`ifdef STOPWATCH_COUNTDOWN_EN
  input  logic        preset_load_i,
  input  logic [23:0] preset_bcd_i,
`endif
  output logic [3:0]  cs_ones_o,
  output logic [3:0]  cs_tens_o,
  output logic [3:0]  sec_ones_o,
  output logic [3:0]  sec_tens_o,
  output logic [3:0]  min_ones_o,
  output logic [3:0]  min_tens_o,
  output logic        running_o,
  output logic        lap_active_o,
  output logic        overflow_o
);

  // FSM encoding
  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_RUN       = 3'd1;
  localparam logic [2:0] c_PAUSE     = 3'd2;
  localparam logic [2:0] c_LAP_RUN   = 3'd3;
  localparam logic [2:0] c_LAP_PAUSE = 3'd4;

  // Largest representable time, 59:59.99, digit 0 = centisecond ones
  localparam logic [23:0] c_MAX = 24'h595999;

  logic [2:0]      state_q, state_d;
  logic [5:0][3:0] cnt_q,   cnt_d;
  logic [5:0][3:0] disp_q,  disp_d;
  logic            ovf_q,   ovf_d;
  logic            tick_q;

  logic            w_inc;
  logic            w_counting;
  logic            w_lap_now;
  logic            w_lap_next;
`ifdef STOPWATCH_COUNTDOWN_EN
  logic            w_done;
`endif

  // Highest legal value of each digit: tens of seconds and tens of minutes
  // roll over at 5, everything else at 9.
  function automatic logic [3:0] digit_max(input int idx);
    return ((idx == 3) || (idx == 5)) ? 4'd5 : 4'd9;
  endfunction

  // Single-cycle ripple increment across all six digits.
  function automatic logic [5:0][3:0] bcd_inc(input logic [5:0][3:0] v);
    logic [5:0][3:0] r;
    logic            carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (v[i] == digit_max(i)) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = v[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

`ifdef STOPWATCH_COUNTDOWN_EN
  // Single-cycle ripple decrement; a zero digit borrows and reloads its max.
  function automatic logic [5:0][3:0] bcd_dec(input logic [5:0][3:0] v);
    logic [5:0][3:0] r;
    logic            borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (v[i] == 4'd0) begin
          r[i] = digit_max(i);
        end else begin
          r[i]   = v[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction
`endif

  // Count qualifier: with edge detection a stuck-high tick counts once.
  assign w_inc      = (EDGE_DETECT != 0) ? (tick_i & ~tick_q) : tick_i;
  // Counting is gated by the registered state, so a tick arriving with a
  // stop pulse still counts and one arriving with a start pulse does not.
  assign w_counting = (state_q == c_RUN) || (state_q == c_LAP_RUN);
  assign w_lap_now  = (state_q == c_LAP_RUN) || (state_q == c_LAP_PAUSE);
  assign w_lap_next = (state_d == c_LAP_RUN) || (state_d == c_LAP_PAUSE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef STOPWATCH_COUNTDOWN_EN
    w_done  = 1'b0;
`endif

    if (clear_i) begin
      // Clear wins over everything, including a coincident tick.
      state_d = c_IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (w_inc && w_counting) begin
`ifdef STOPWATCH_COUNTDOWN_EN
        if (cnt_q == '0) begin
          ovf_d  = 1'b1;
          w_done = 1'b1;
        end else begin
          cnt_d = bcd_dec(cnt_q);
          if (cnt_d == '0) begin
            ovf_d  = 1'b1;
            w_done = 1'b1;
          end
        end
`else
        if (cnt_q == c_MAX) begin
          ovf_d = 1'b1;
          cnt_d = (SATURATE != 0) ? cnt_q : '0;
        end else begin
          cnt_d = bcd_inc(cnt_q);
        end
`endif
      end

      // lap has priority over start_stop; the loser is discarded.
      if (lap_i) begin
        case (state_q)
          c_RUN:       state_d = c_LAP_RUN;
          c_LAP_RUN:   state_d = c_RUN;
          c_LAP_PAUSE: state_d = c_PAUSE;
          default:     state_d = state_q;
        endcase
      end else if (start_stop_i) begin
        case (state_q)
          c_IDLE:      state_d = c_RUN;
          c_RUN:       state_d = c_PAUSE;
          c_PAUSE:     state_d = c_RUN;
          c_LAP_RUN:   state_d = c_LAP_PAUSE;
          c_LAP_PAUSE: state_d = c_LAP_RUN;
          default:     state_d = c_IDLE;
        endcase
      end

`ifdef STOPWATCH_COUNTDOWN_EN
      // Reaching zero ends the countdown regardless of any button pulse.
      if (w_done) begin
        state_d = c_PAUSE;
      end
      if (preset_load_i && (state_q == c_IDLE)) begin
        cnt_d = preset_bcd_i;
      end
`endif
    end
  end

  // The display follows the count on the same edge except while staying
  // inside the lap states; on lap entry the freshly computed count is
  // captured and then held until lap is released.
  always_comb begin
    disp_d = cnt_d;
    if (w_lap_now && w_lap_next) begin
      disp_d = disp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      tick_q  <= tick_i;
    end
  end

  assign cs_ones_o    = disp_q[0];
  assign cs_tens_o    = disp_q[1];
  assign sec_ones_o   = disp_q[2];
  assign sec_tens_o   = disp_q[3];
  assign min_ones_o   = disp_q[4];
  assign min_tens_o   = disp_q[5];
  assign running_o    = w_counting;
  assign lap_active_o = w_lap_now;
  assign overflow_o   = ovf_q;

endmodule

`default_nettype wire
